// File: rtl/multi_channel_data_synchronizer.sv
// Destination-domain CDC receiver: per-channel enable synchronizer, level/toggle event
// detect, one-entry capture buffer with valid/ready, ack toggle back to source, sticky overrun.

module mcds_lane #(
  parameter int NUM_STAGES  = 3,
  parameter int BUS_WIDTH   = 8,
  parameter int TOGGLE_MODE = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en_in,
  input  logic [BUS_WIDTH-1:0] data_in,
  input  logic                 ready_in,
  input  logic                 clr_in,
  output logic                 valid_out,
  output logic [BUS_WIDTH-1:0] data_out,
  output logic                 pulse_out,
  output logic                 ack_out,
  output logic                 ovr_out
);
  logic [NUM_STAGES-1:0] sync_q, sync_d;
  logic                  prev_q, prev_d;
  logic                  valid_q, valid_d;
  logic [BUS_WIDTH-1:0]  data_q, data_d;
  logic                  pulse_q, pulse_d;
  logic                  ack_q, ack_d;
  logic                  ovr_q, ovr_d;
  logic                  s, evt;

  assign s   = sync_q[NUM_STAGES-1];
  assign evt = (TOGGLE_MODE != 0) ? (s ^ prev_q) : (s & ~prev_q);

  always_comb begin
    sync_d  = {sync_q[NUM_STAGES-2:0], en_in};
    prev_d  = s;
    valid_d = valid_q;
    data_d  = data_q;
    pulse_d = 1'b0;
    ack_d   = ack_q;
    ovr_d   = ovr_q & ~clr_in;
    if (!valid_q) begin
      if (evt) begin
        valid_d = 1'b1;
        data_d  = data_in;
        pulse_d = 1'b1;
      end
    end else if (ready_in) begin
      // Draining and refilling in one cycle is a legal handoff, not an overrun.
      ack_d = ~ack_q;
      if (evt) begin
        data_d  = data_in;
        pulse_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end else if (evt) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      pulse_q <= 1'b0;
      ack_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      pulse_q <= pulse_d;
      ack_q   <= ack_d;
      ovr_q   <= ovr_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign pulse_out = pulse_q;
  assign ack_out   = ack_q;
  assign ovr_out   = ovr_q;
endmodule

module multi_channel_data_synchronizer #(
  parameter int NUM_STAGES   = 3,
  parameter int BUS_WIDTH    = 8,
  parameter int NUM_CHANNELS = 2,
  parameter int TOGGLE_MODE  = 0
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_CHANNELS-1:0]           bus_enable_in,
  input  logic [NUM_CHANNELS*BUS_WIDTH-1:0] unsync_data_in,
  input  logic [NUM_CHANNELS-1:0]           sync_ready_in,
  input  logic [NUM_CHANNELS-1:0]           overrun_clear_in,
  output logic [NUM_CHANNELS-1:0]           sync_valid_out,
  output logic [NUM_CHANNELS*BUS_WIDTH-1:0] sync_data_out,
  output logic [NUM_CHANNELS-1:0]           enable_pulse_out,
  output logic [NUM_CHANNELS-1:0]           ack_toggle_out,
  output logic [NUM_CHANNELS-1:0]           overrun_out
);
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    mcds_lane #(
      .NUM_STAGES (NUM_STAGES),
      .BUS_WIDTH  (BUS_WIDTH),
      .TOGGLE_MODE(TOGGLE_MODE)
    ) u_lane (
      .clk      (clk),
      .reset_n  (reset_n),
      .en_in    (bus_enable_in[c]),
      .data_in  (unsync_data_in[c*BUS_WIDTH +: BUS_WIDTH]),
      .ready_in (sync_ready_in[c]),
      .clr_in   (overrun_clear_in[c]),
      .valid_out(sync_valid_out[c]),
      .data_out (sync_data_out[c*BUS_WIDTH +: BUS_WIDTH]),
      .pulse_out(enable_pulse_out[c]),
      .ack_out  (ack_toggle_out[c]),
      .ovr_out  (overrun_out[c])
    );
  end
endmodule

// File: tb/tb_multi_channel_data_synchronizer.sv
// Bench for multi_channel_data_synchronizer: a level-mode and a toggle-mode instance share
// inputs; both are compared every cycle against an enable-history reference model.

module tb_multi_channel_data_synchronizer;
  localparam int NS = 3, BW = 8, NC = 2;

  logic clk = 1'b0, reset_n = 1'b0;
  logic [NC-1:0]    en = '0, rdy = '0, clr = '0;
  logic [NC*BW-1:0] din = '0;
  logic [NC-1:0]    vld [2], pls [2], ack [2], ovr [2];
  logic [NC*BW-1:0] dout [2];

  always #5 clk = ~clk;

  multi_channel_data_synchronizer #(.NUM_STAGES(NS), .BUS_WIDTH(BW), .NUM_CHANNELS(NC),
    .TOGGLE_MODE(0)) u_lvl (
    .clk(clk), .reset_n(reset_n), .bus_enable_in(en), .unsync_data_in(din),
    .sync_ready_in(rdy), .overrun_clear_in(clr), .sync_valid_out(vld[0]),
    .sync_data_out(dout[0]), .enable_pulse_out(pls[0]), .ack_toggle_out(ack[0]),
    .overrun_out(ovr[0]));

  multi_channel_data_synchronizer #(.NUM_STAGES(NS), .BUS_WIDTH(BW), .NUM_CHANNELS(NC),
    .TOGGLE_MODE(1)) u_tog (
    .clk(clk), .reset_n(reset_n), .bus_enable_in(en), .unsync_data_in(din),
    .sync_ready_in(rdy), .overrun_clear_in(clr), .sync_valid_out(vld[1]),
    .sync_data_out(dout[1]), .enable_pulse_out(pls[1]), .ack_toggle_out(ack[1]),
    .overrun_out(ovr[1]));

  // Reference model: enable samples since reset, plus per-mode/per-channel buffer state.
  logic [NC-1:0] en_log [$];
  bit            mfull [2][NC], mpls [2][NC], mack [2][NC], movr [2][NC];
  logic [BW-1:0] mdata [2][NC];
  int total = 0, bad = 0;

  function automatic void model_reset();
    en_log.delete();
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < NC; c++) begin
        mfull[m][c] = 0; mpls[m][c] = 0; mack[m][c] = 0; movr[m][c] = 0; mdata[m][c] = '0;
      end
  endfunction

  // Enable value sampled `ago` edges before the current one (0 before reset release).
  function automatic bit en_at(int c, int ago);
    int idx = en_log.size() - ago;
    return (idx >= 0) ? en_log[idx][c] : 1'b0;
  endfunction

  function automatic void model_edge();
    for (int c = 0; c < NC; c++) begin
      bit s = en_at(c, NS);
      bit p = en_at(c, NS + 1);
      for (int m = 0; m < 2; m++) begin
        bit ev = (m == 1) ? (s ^ p) : (s & ~p);
        bit was_full = mfull[m][c];
        mpls[m][c] = 0;
        movr[m][c] = (movr[m][c] & ~clr[c]) | (was_full & ~rdy[c] & ev);
        if (!was_full) begin
          if (ev) begin mfull[m][c] = 1; mdata[m][c] = din[c*BW +: BW]; mpls[m][c] = 1; end
        end else if (rdy[c]) begin
          mack[m][c] = ~mack[m][c];
          if (ev) begin mdata[m][c] = din[c*BW +: BW]; mpls[m][c] = 1; end
          else mfull[m][c] = 0;
        end
      end
    end
    en_log.push_back(en);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < NC; c++) begin
        chk($sformatf("m%0d.c%0d.valid", m, c), 32'(vld[m][c]), 32'(mfull[m][c]));
        chk($sformatf("m%0d.c%0d.data", m, c), 32'(dout[m][c*BW +: BW]), 32'(mdata[m][c]));
        chk($sformatf("m%0d.c%0d.pulse", m, c), 32'(pls[m][c]), 32'(mpls[m][c]));
        chk($sformatf("m%0d.c%0d.ack", m, c), 32'(ack[m][c]), 32'(mack[m][c]));
        chk($sformatf("m%0d.c%0d.ovr", m, c), 32'(ovr[m][c]), 32'(movr[m][c]));
      end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_edge();
    #1;
    check_all();
  endtask

  task automatic run(int n);
    repeat (n) tick();
  endtask

  initial begin
    model_reset();
    #1 check_all();
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    tick();

    // Level capture on ch0: three cycles of sync latency, capture on the fourth sampled edge.
    din[0 +: BW] = 8'h3C; en[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lvl.latency.valid0", 32'(vld[0][0]), 32'd0);
    end
    tick();
    chk("lvl.cap.valid0", 32'(vld[0][0]), 32'd1);
    chk("lvl.cap.data0", 32'(dout[0][0 +: BW]), 32'h3C);
    chk("lvl.cap.pulse0", 32'(pls[0][0]), 32'd1);
    tick();
    chk("lvl.pulse_drop0", 32'(pls[0][0]), 32'd0);
    rdy[0] = 1'b1; tick(); rdy[0] = 1'b0;
    chk("lvl.drain.valid0", 32'(vld[0][0]), 32'd0);
    chk("lvl.drain.ack0", 32'(ack[0][0]), 32'd1);

    // Toggle mode on ch1: rise carries 0x11, fall carries 0x22.
    din[BW +: BW] = 8'h11; en[1] = 1'b1;
    run(4);
    chk("tog.cap1.data1", 32'(dout[1][BW +: BW]), 32'h11);
    chk("tog.cap1.pulse1", 32'(pls[1][1]), 32'd1);
    rdy[1] = 1'b1; tick(); rdy[1] = 1'b0;
    chk("tog.ack1.first", 32'(ack[1][1]), 32'd1);
    din[BW +: BW] = 8'h22; en[1] = 1'b0;
    run(4);
    chk("tog.cap2.valid1", 32'(vld[1][1]), 32'd1);
    chk("tog.cap2.data1", 32'(dout[1][BW +: BW]), 32'h22);
    chk("tog.cap2.pulse1", 32'(pls[1][1]), 32'd1);
    chk("lvl.fall_no_event.valid1", 32'(vld[0][1]), 32'd0);
    rdy[1] = 1'b1; tick(); rdy[1] = 1'b0;
    chk("tog.ack1.second", 32'(ack[1][1]), 32'd0);
    chk("lvl.empty_ready_ignored.ack1", 32'(ack[0][1]), 32'd1);

    // Overrun on level ch0: full with 0x55, new event with 0x66 while not ready.
    en[0] = 1'b0; run(2);
    din[0 +: BW] = 8'h55; en[0] = 1'b1; run(4);
    chk("ovr.fill.data0", 32'(dout[0][0 +: BW]), 32'h55);
    en[0] = 1'b0; run(2);
    din[0 +: BW] = 8'h66; en[0] = 1'b1; run(4);
    chk("ovr.hold.data0", 32'(dout[0][0 +: BW]), 32'h55);
    chk("ovr.set.ovr0", 32'(ovr[0][0]), 32'd1);
    chk("ovr.no_pulse0", 32'(pls[0][0]), 32'd0);
    clr[0] = 1'b1; tick(); clr[0] = 1'b0;
    chk("ovr.clear.ovr0", 32'(ovr[0][0]), 32'd0);

    // Drain and refill in the same cycle on level ch0.
    rdy[0] = 1'b1; tick(); rdy[0] = 1'b0;
    en[0] = 1'b0; run(2);
    din[0 +: BW] = 8'h01; en[0] = 1'b1; run(4);
    chk("df.fill.data0", 32'(dout[0][0 +: BW]), 32'h01);
    en[0] = 1'b0; run(2);
    din[0 +: BW] = 8'h02; en[0] = 1'b1; run(3);
    rdy[0] = 1'b1; tick(); rdy[0] = 1'b0;
    chk("df.data0", 32'(dout[0][0 +: BW]), 32'h02);
    chk("df.valid0", 32'(vld[0][0]), 32'd1);
    chk("df.pulse0", 32'(pls[0][0]), 32'd1);
    chk("df.ack0", 32'(ack[0][0]), 32'd1);
    chk("df.ovr0", 32'(ovr[0][0]), 32'd0);

    // Independence: simultaneous events, only ch1 drained.
    rdy[0] = 1'b1; tick(); rdy[0] = 1'b0;
    en = '0; run(2);
    din = {8'hBB, 8'hAA}; en = '1; run(4);
    chk("ind.valid0", 32'(vld[0][0]), 32'd1);
    chk("ind.valid1", 32'(vld[0][1]), 32'd1);
    rdy[1] = 1'b1; tick(); rdy[1] = 1'b0;
    chk("ind.ch1.valid", 32'(vld[0][1]), 32'd0);
    chk("ind.ch1.ack", 32'(ack[0][1]), 32'd0);
    chk("ind.ch0.valid", 32'(vld[0][0]), 32'd1);
    chk("ind.ch0.data", 32'(dout[0][0 +: BW]), 32'hAA);

    // Asynchronous reset mid-transfer, checked before any clock edge.
    #1 reset_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("rst.m%0d.valid", m), 32'(vld[m]), 32'd0);
      chk($sformatf("rst.m%0d.data", m), 32'(dout[m]), 32'd0);
      chk($sformatf("rst.m%0d.pulse", m), 32'(pls[m]), 32'd0);
      chk($sformatf("rst.m%0d.ack", m), 32'(ack[m]), 32'd0);
      chk($sformatf("rst.m%0d.ovr", m), 32'(ovr[m]), 32'd0);
    end
    model_reset();
    en = '0; rdy = '0; clr = '0; din = '0;
    @(negedge clk) reset_n = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NC; c++) begin
        if ($urandom_range(0, 4) == 0) en[c] = ~en[c];
        rdy[c] = ($urandom_range(0, 2) == 0);
        clr[c] = ($urandom_range(0, 7) == 0);
      end
      din = NC*BW'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
